// File: rtl/draw_player_anim.sv
// draw_player_anim: frame-synchronous player sprite overlay with a two-phase walk animation
//   clk, rst                        pixel clock, synchronous active-high reset
//   i_vcount .. i_rgb               vga timing and colour from the previous pipeline stage
//   o_vcount .. o_rgb               the same fields delayed by 2 cycles, sprite drawn over rgb
//   i_xpos_player                   sprite left column in screen pixels
//   i_ypos_player                   vertical offset added to Y_TOP
//   i_state                         player state selecting the front or side view
package state_pkg;
    typedef enum logic [2:0] {IDLE, LEFT1, LEFT2, RIGHT1, RIGHT2} state_t;
endpackage

module draw_player_anim
    import state_pkg::*;
#(
    parameter int          W           = 40,
    parameter int          H           = 90,
    parameter int          Y_TOP       = 410,
    parameter logic [11:0] BODY_RGB    = 12'hF00,
    parameter logic [11:0] EYE_RGB     = 12'h0FF,
    parameter int          EYE_R2      = 30,
    parameter int          ANIM_FRAMES = 8,
    parameter int          LEG_LIFT    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] i_vcount,
    input  logic        i_vsync,
    input  logic        i_vblnk,
    input  logic [11:0] i_hcount,
    input  logic        i_hsync,
    input  logic        i_hblnk,
    input  logic [11:0] i_rgb,
    input  logic [11:0] i_xpos_player,
    input  logic [11:0] i_ypos_player,
    input  state_t      i_state,
    output logic [11:0] o_vcount,
    output logic        o_vsync,
    output logic        o_vblnk,
    output logic [11:0] o_hcount,
    output logic        o_hsync,
    output logic        o_hblnk,
    output logic [11:0] o_rgb
);
    localparam int CW = ANIM_FRAMES > 1 ? $clog2(ANIM_FRAMES) : 1;

    logic          r_vblnk_d;
    logic [11:0]   r_x0;
    logic [12:0]   r_y0;
    state_t        r_st;
    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic [11:0]   r1_vcount, r1_hcount, r1_rgb;
    logic          r1_vsync, r1_vblnk, r1_hsync, r1_hblnk, r1_in_box;
    logic [12:0]   r1_lx, r1_ly;

    logic                w_vsof, w_last, w_in_box;
    logic [12:0]         w_h13, w_v13;
    logic signed [28:0]  w_dy, w_dx_l, w_dx_r;
    logic                w_eye_f, w_solid_f, w_lift, w_left, w_eye_s, w_rear, w_body_s, w_draw;
    logic [12:0]         w_ear_w, w_c0;
    logic [11:0]         w_rgb;

    assign w_vsof = i_vblnk & ~r_vblnk_d;
    assign w_last = r_cnt == CW'(ANIM_FRAMES - 1);

    // 13-bit box bounds: a sprite hanging past column/row 4095 is clipped instead of wrapping
    assign w_h13    = {1'b0, i_hcount};
    assign w_v13    = {1'b0, i_vcount};
    assign w_in_box = w_h13 >= {1'b0, r_x0} && w_h13 < {1'b0, r_x0} + 13'(W)
                   && w_v13 >= r_y0 && w_v13 < r_y0 + 13'(H);

    // front view: two round eyes, body block, stepped ears, two legs (left one liftable)
    assign w_dy      = $signed({16'b0, r1_ly}) - 29'sd30;
    assign w_dx_l    = $signed({16'b0, r1_lx}) - 29'sd10;
    assign w_dx_r    = $signed({16'b0, r1_lx}) - $signed(29'(W - 13));
    assign w_eye_f   = (w_dy * w_dy + w_dx_l * w_dx_l <= $signed(29'(EYE_R2)))
                    || (w_dy * w_dy + w_dx_r * w_dx_r <= $signed(29'(EYE_R2)));
    assign w_ear_w   = r1_ly >= 13'd5 ? 13'd15 : 13'd10;
    assign w_lift    = r_phase && r_st != IDLE && r1_ly >= 13'(H - LEG_LIFT);
    assign w_solid_f = (r1_ly >= 13'd10 && r1_ly < 13'(H - 20))
                    || (r1_ly < 13'd10 && (r1_lx < w_ear_w || r1_lx >= 13'(W) - w_ear_w))
                    || (r1_ly >= 13'(H - 20) && ((r1_lx < 13'd15 && !w_lift) || r1_lx >= 13'(W - 15)));

    // side view: body/legs span W-15 columns starting at w_c0; the rear leg half is the one
    // away from the facing edge and is the one shortened on phase 1
    assign w_left   = r_st == LEFT2;
    assign w_c0     = w_left ? 13'd5 : 13'd0;
    assign w_eye_s  = r1_ly >= 13'd20 && r1_ly < 13'd40
                   && (w_left ? r1_lx < 13'd5 : (r1_lx >= 13'(W - 15) && r1_lx <= 13'(W - 11)));
    assign w_rear   = w_left ? r1_lx >= w_c0 + 13'((W - 15) / 2) : r1_lx < w_c0 + 13'((W - 15) / 2);
    assign w_body_s = r1_lx >= w_c0 && r1_lx <= w_c0 + 13'(W - 16)
                   && !(r_phase && w_rear && r1_ly >= 13'(H - LEG_LIFT));

    assign w_draw = r1_in_box && !(r1_hblnk || r1_vblnk);

    always_comb begin
        w_rgb = r1_rgb;
        if (w_draw && (r_st == IDLE || r_st == LEFT1 || r_st == RIGHT1))
            w_rgb = w_eye_f ? EYE_RGB : w_solid_f ? BODY_RGB : r1_rgb;
        else if (w_draw)
            w_rgb = w_eye_s ? EYE_RGB : w_body_s ? BODY_RGB : r1_rgb;
    end

    // shadow position/state and animation only move at the start of vertical blanking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblnk_d <= 1'b0;
            r_x0      <= '0;
            r_y0      <= '0;
            r_st      <= IDLE;
            r_cnt     <= '0;
            r_phase   <= 1'b0;
        end else begin
            r_vblnk_d <= i_vblnk;
            if (w_vsof) begin
                r_x0    <= i_xpos_player;
                r_y0    <= 13'(Y_TOP) + {1'b0, i_ypos_player};
                r_st    <= i_state;
                r_cnt   <= (i_state == IDLE || w_last) ? '0 : r_cnt + 1'b1;
                r_phase <= (i_state == IDLE) ? 1'b0 : r_phase ^ w_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_vcount <= '0;
            r1_vsync  <= 1'b0;
            r1_vblnk  <= 1'b0;
            r1_hcount <= '0;
            r1_hsync  <= 1'b0;
            r1_hblnk  <= 1'b0;
            r1_rgb    <= '0;
            r1_in_box <= 1'b0;
            r1_lx     <= '0;
            r1_ly     <= '0;
            o_vcount  <= '0;
            o_vsync   <= 1'b0;
            o_vblnk   <= 1'b0;
            o_hcount  <= '0;
            o_hsync   <= 1'b0;
            o_hblnk   <= 1'b0;
            o_rgb     <= '0;
        end else begin
            r1_vcount <= i_vcount;
            r1_vsync  <= i_vsync;
            r1_vblnk  <= i_vblnk;
            r1_hcount <= i_hcount;
            r1_hsync  <= i_hsync;
            r1_hblnk  <= i_hblnk;
            r1_rgb    <= i_rgb;
            r1_in_box <= w_in_box;
            r1_lx     <= w_h13 - {1'b0, r_x0};
            r1_ly     <= w_v13 - r_y0;
            o_vcount  <= r1_vcount;
            o_vsync   <= r1_vsync;
            o_vblnk   <= r1_vblnk;
            o_hcount  <= r1_hcount;
            o_hsync   <= r1_hsync;
            o_hblnk   <= r1_hblnk;
            o_rgb     <= w_rgb;
        end
    end
endmodule

// File: tb/tb_draw_player_anim.sv
// tb_draw_player_anim: scoreboard bench for draw_player_anim against a pixel-rule reference model
module tb_draw_player_anim;
    import state_pkg::*;

    localparam int          W = 40, H = 90, Y_TOP = 410, EYE_R2 = 30, AF = 2, LIFT = 6;
    localparam logic [11:0] BODY = 12'hF00, EYE = 12'h0FF, BG = 12'h123;

    typedef struct packed {
        logic [11:0] vc;
        logic        vs;
        logic        vb;
        logic [11:0] hc;
        logic        hs;
        logic        hb;
        logic [11:0] rgb;
    } vga_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic [11:0] i_vcount = '0, i_hcount = '0, i_rgb = '0, i_xpos = '0, i_ypos = '0;
    logic        i_vsync = 1'b0, i_vblnk = 1'b0, i_hsync = 1'b0, i_hblnk = 1'b0;
    state_t      i_state = IDLE;
    logic [11:0] o_vcount, o_hcount, o_rgb;
    logic        o_vsync, o_vblnk, o_hsync, o_hblnk;

    int   n_cmp = 0, n_bad = 0;
    vga_t q[$];

    always #5 clk = ~clk;

    draw_player_anim #(.ANIM_FRAMES(AF)) dut (
        .clk(clk), .rst(rst),
        .i_vcount(i_vcount), .i_vsync(i_vsync), .i_vblnk(i_vblnk),
        .i_hcount(i_hcount), .i_hsync(i_hsync), .i_hblnk(i_hblnk), .i_rgb(i_rgb),
        .i_xpos_player(i_xpos), .i_ypos_player(i_ypos), .i_state(i_state),
        .o_vcount(o_vcount), .o_vsync(o_vsync), .o_vblnk(o_vblnk),
        .o_hcount(o_hcount), .o_hsync(o_hsync), .o_hblnk(o_hblnk), .o_rgb(o_rgb)
    );

    // colour of sprite-local pixel (lx, ly) straight from the drawing rules
    function automatic logic [11:0] paint(input int lx, input int ly, input state_t st,
                                          input bit ph, input logic [11:0] bg);
        bit lifted;
        int ear, c0, mid;
        bit rear;
        lifted = ph && ly >= H - LIFT;
        if (st == IDLE || st == LEFT1 || st == RIGHT1) begin
            if ((ly-30)*(ly-30) + (lx-10)*(lx-10) <= EYE_R2 ||
                (ly-30)*(ly-30) + (lx-(W-13))*(lx-(W-13)) <= EYE_R2) return EYE;
            if (ly >= 10 && ly < H - 20) return BODY;
            ear = (ly >= 5) ? 15 : 10;
            if (ly < 10) return (lx < ear || lx >= W - ear) ? BODY : bg;
            if (lx >= W - 15 || (lx < 15 && !(lifted && st != IDLE))) return BODY;
            return bg;
        end
        c0  = (st == LEFT2) ? 5 : 0;
        mid = c0 + (W - 15) / 2;
        if (ly >= 20 && ly < 40 && (st == LEFT2 ? lx < 5 : (lx >= W - 15 && lx <= W - 11))) return EYE;
        if (lx < c0 || lx > c0 + W - 16) return bg;
        rear = (st == LEFT2) ? lx >= mid : lx < mid;
        return (ly >= H - 20 && rear && lifted) ? bg : BODY;
    endfunction

    // reference model: frame latch, animation counter and a 2-deep delay line of expected outputs
    int     m_x0, m_y0, m_cnt, lx, ly;
    state_t m_st;
    bit     m_ph, m_vd;
    vga_t   p1, p2, cur;
    initial forever begin
        @(posedge clk);
        if (rst) begin
            p1 = '0; p2 = '0; m_x0 = 0; m_y0 = 0; m_st = IDLE; m_cnt = 0; m_ph = 0; m_vd = 0;
        end else begin
            cur = '{i_vcount, i_vsync, i_vblnk, i_hcount, i_hsync, i_hblnk, i_rgb};
            lx = int'(i_hcount) - m_x0;
            ly = int'(i_vcount) - m_y0;
            if (!i_hblnk && !i_vblnk && lx >= 0 && lx < W && ly >= 0 && ly < H)
                cur.rgb = paint(lx, ly, m_st, m_ph, i_rgb);
            p2 = p1;
            p1 = cur;
            if (i_vblnk && !m_vd) begin
                m_x0 = int'(i_xpos);
                m_y0 = Y_TOP + int'(i_ypos);
                m_st = i_state;
                if (i_state == IDLE) begin
                    m_cnt = 0; m_ph = 0;
                end else if (m_cnt == AF - 1) begin
                    m_cnt = 0; m_ph = !m_ph;
                end else m_cnt++;
            end
            m_vd = i_vblnk;
        end
        q.push_back(p2);
    end

    vga_t exp_v, act_v;
    initial forever begin
        @(negedge clk);
        if (q.size() != 0) begin
            exp_v = q.pop_front();
            act_v = {o_vcount, o_vsync, o_vblnk, o_hcount, o_hsync, o_hblnk, o_rgb};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL vga_out @%0t: got vc=%h vs=%b vb=%b hc=%h hs=%b hb=%b rgb=%h, expected vc=%h vs=%b vb=%b hc=%h hs=%b hb=%b rgb=%h",
                         $time, act_v.vc, act_v.vs, act_v.vb, act_v.hc, act_v.hs, act_v.hb, act_v.rgb,
                         exp_v.vc, exp_v.vs, exp_v.vb, exp_v.hc, exp_v.hs, exp_v.hb, exp_v.rgb);
            end
        end
    end

    task automatic step(input logic [11:0] h, input logic [11:0] v, input logic hb, input logic vb,
                        input logic [11:0] rgb);
        i_hcount = h; i_vcount = v; i_hblnk = hb; i_vblnk = vb; i_rgb = rgb;
        i_hsync = 1'($urandom); i_vsync = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic filler(input int n);
        repeat (n) step(12'($urandom), 12'($urandom), 1'($urandom), 1'b0, 12'($urandom));
    endtask

    // one vblank pulse latching x/y/state, then scramble the inputs to show they are ignored
    task automatic new_frame(input logic [11:0] x, input logic [11:0] y, input state_t s);
        i_xpos = x; i_ypos = y; i_state = s;
        step(12'($urandom), 12'($urandom), 1'b1, 1'b1, 12'($urandom));
        step(12'($urandom), 12'($urandom), 1'b1, 1'b1, 12'($urandom));
        step(12'($urandom), 12'($urandom), 1'b0, 1'b0, 12'($urandom));
        i_xpos = 12'($urandom); i_ypos = 12'($urandom); i_state = state_t'($urandom_range(0, 4));
    endtask

    task automatic check_px(input logic [11:0] h, input logic [11:0] v, input logic [11:0] want,
                            input string name);
        step(h, v, 1'b0, 1'b0, BG);
        step(12'($urandom), 12'($urandom), 1'b0, 1'b0, 12'($urandom));
        n_cmp++;
        if (o_rgb !== want) begin
            n_bad++;
            $display("FAIL %s (%0d,%0d): o_rgb=%h expected %h", name, h, v, o_rgb, want);
        end
    endtask

    task automatic check_vec(input vga_t want, input string name);
        n_cmp++;
        if ({o_vcount, o_vsync, o_vblnk, o_hcount, o_hsync, o_hblnk, o_rgb} !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name,
                     {o_vcount, o_vsync, o_vblnk, o_hcount, o_hsync, o_hblnk, o_rgb}, want);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    vga_t d1;
    int   x, y, y0;
    initial begin
        repeat (2) filler(1);
        rst = 1'b0;
        new_frame(12'd100, 12'd0, RIGHT2);
        filler(5);
        // reset mid-line for three cycles
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            filler(1);
            check_vec('0, "reset_zero");
        end
        rst = 1'b0;
        d1 = '{12'h345, 1'b1, 1'b0, 12'h234, 1'b0, 1'b1, 12'hABC};
        i_hsync = 1'b0; i_vsync = 1'b1;
        i_hcount = d1.hc; i_vcount = d1.vc; i_hblnk = 1'b1; i_vblnk = 1'b0; i_rgb = d1.rgb;
        @(posedge clk);
        #1;
        check_vec('0, "release_first_cycle");
        filler(1);
        check_vec(d1, "release_latency");
        check_px(12'd10, 12'd30, EYE, "post_reset_idle_origin");

        // passthrough raster with the sprite parked off-screen
        new_frame(12'd4000, 12'd0, IDLE);
        for (int v = 0; v < 3; v++)
            for (int h = 0; h < 800; h++) step(12'(h), 12'(400 + v), h >= 640, 1'b0, BG);

        new_frame(12'd100, 12'd0, IDLE);
        check_px(12'd110, 12'd440, EYE,  "idle_eye");
        check_px(12'd120, 12'd450, BODY, "idle_body");
        check_px(12'd104, 12'd412, BODY, "idle_ear");
        check_px(12'd120, 12'd412, BG,   "idle_between_ears");
        check_px(12'd99,  12'd450, BG,   "idle_left_of_box");

        // position change mid-frame takes effect only at the next frame
        i_xpos = 12'd300;
        step(12'd0, 12'd200, 1'b0, 1'b0, BG);
        check_px(12'd110, 12'd440, EYE, "old_x_holds");
        check_px(12'd310, 12'd440, BG,  "new_x_not_yet");
        new_frame(12'd300, 12'd0, IDLE);
        check_px(12'd310, 12'd440, EYE, "new_x_frame");
        check_px(12'd110, 12'd440, BG,  "old_x_gone");

        // walk phases: phase after the i-th moving frame is (i / AF) % 2
        for (int i = 1; i <= 5; i++) begin
            new_frame(12'd100, 12'd0, RIGHT2);
            check_px(12'd102, 12'd495, ((i / AF) % 2) ? BG : BODY, "right2_rear_leg");
            check_px(12'd120, 12'd495, BODY, "right2_front_leg");
        end
        new_frame(12'd100, 12'd0, IDLE);
        check_px(12'd102, 12'd495, BODY, "idle_left_leg_full");
        check_px(12'd135, 12'd495, BODY, "idle_right_leg");
        new_frame(12'd100, 12'd0, RIGHT2);
        check_px(12'd102, 12'd495, BODY, "restart_phase0");
        new_frame(12'd100, 12'd0, RIGHT2);
        check_px(12'd102, 12'd495, BG, "restart_phase1");

        // clipping at the right/bottom screen edge, no wrap-around
        new_frame(12'd4080, 12'd0, IDLE);
        check_px(12'd4090, 12'd440, EYE, "clip_x_eye");
        check_px(12'd5,    12'd440, BG,  "no_wrap_x");
        new_frame(12'd100, 12'd3650, IDLE);
        check_px(12'd110, 12'd4090, EYE, "clip_y_eye");
        new_frame(12'd100, 12'd3700, IDLE);
        check_px(12'd110, 12'd44, BG, "no_wrap_y0");

        // random frames, pixels concentrated around the sprite box
        for (int f = 0; f < 24; f++) begin
            x = (f % 5 == 4) ? int'($urandom_range(4040, 4095)) : int'($urandom_range(0, 700));
            y = (f % 7 == 6) ? int'($urandom_range(3600, 3700)) : int'($urandom_range(0, 120));
            new_frame(12'(x), 12'(y), state_t'($urandom_range(0, 4)));
            y0 = Y_TOP + y;
            repeat (300)
                step(12'(x + int'($urandom_range(0, W + 3)) - 2), 12'(y0 + int'($urandom_range(0, H + 3)) - 2),
                     $urandom_range(0, 7) == 0, 1'b0, 12'($urandom));
        end
        filler(4);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
